window_scan_ctrl: RTL

Frame sequencer for the windowed pixel-processing datapath. Accepts the host pixel stream over a valid/ready handshake and produces the raster address, row and column of each accepted pixel. Generates a single advance enable that steps the windowed datapath, and delivers a delay-matched interior flag (`win_ok`) so the datapath outputs black for border pixels. Sits between the host receive path and the systolic window array; one instance per image pipeline.

---
 rtl/win_scan_pkg.sv | 23 ++
 rtl/valid_delay_line.sv | 25 ++
 rtl/window_scan_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/win_scan_pkg.sv
// Shared types and defaults for the window scan controller: FSM state
// encoding, default image geometry and the interior-window predicate.
package win_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_BORDER = 2;

    // True when (r, c) has a full window, i.e. lies outside the border band.
    function automatic logic is_interior(input int r, input int c,
                                         input int w, input int h,
                                         input int b);
        return (r >= b) && (r <= h - 1 - b) && (c >= b) && (c <= w - 1 - b);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Enable-gated shift register carrying per-pixel flags alongside the
// windowed datapath; every stage is visible so the caller can test occupancy.
module valid_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [WIDTH-1:0]              din,
    output logic [DEPTH-1:0][WIDTH-1:0]   stages
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else if (en) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the windowed pixel datapath: raster counters, advance
// enable and delay-matched valid/interior flags. Optional frame counter under
// macro WSC_FRAME_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels from the host
// DRAIN | all pixels taken, flushing the datapath pipeline
// DONE  | one-cycle frame_done pulse
module window_scan_ctrl
    import win_scan_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int BORDER   = DEF_BORDER,
    parameter int PIPE_DLY = 2,
    parameter int AW       = 19
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic                       out_ready,
    output logic                       dp_en,
    output logic [AW-1:0]              pix_addr,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic                       out_valid,
    output logic                       win_ok,
    output logic                       busy,
    output logic                       frame_done
`ifdef WSC_FRAME_CNT_EN
    ,
    output logic [15:0]                frame_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

    scan_state_t state_q, state_d;

    logic [AW-1:0]  addr_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;

    logic adv;
    logic accept;
    logic last_pix;
    logic interior;
    logic pend_next;

    logic [PIPE_DLY-1:0][1:0] stages;
    logic [PIPE_DLY-1:0]      vld_vec;
    logic [PIPE_DLY-1:0]      vld_shift;

    assign pix_ready = (state_q == RUN) & out_ready;
    assign adv       = out_ready & ((state_q == RUN) | (state_q == DRAIN));
    assign accept    = pix_ready & pix_valid;
    assign last_pix  = (addr_q == ADDR_LAST);
    assign interior  = is_interior(int'(row_q), int'(col_q), IMG_W, IMG_H, BORDER);

    assign dp_en      = adv;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign pix_addr   = addr_q;
    assign col        = col_q;
    assign row        = row_q;

    valid_delay_line #(
        .DEPTH (PIPE_DLY),
        .WIDTH (2)
    ) u_dly (
        .clk    (clk),
        .reset  (reset),
        .en     (adv),
        .din    ({interior, accept}),
        .stages (stages)
    );

    always_comb begin
        vld_vec = '0;
        for (int i = 0; i < PIPE_DLY; i++) begin
            vld_vec[i] = stages[i][0];
        end
    end

    // Look at occupancy after this edge so frame_done follows the last
    // consumed result by exactly one cycle.
    assign vld_shift = vld_vec << 1;
    assign pend_next = adv ? (|vld_shift) : (|vld_vec);

    assign out_valid = stages[PIPE_DLY-1][0];
    assign win_ok    = stages[PIPE_DLY-1][1] & stages[PIPE_DLY-1][0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (!pend_next) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (state_q == IDLE && start) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (accept && !last_pix) begin
            addr_q <= addr_q + AW'(1);
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

`ifdef WSC_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
